// File: rtl/seg_disp_sched.sv
// seg_disp_sched: time-shares a 4-digit BCD display (hun.ten.one.dot) between
// SRC_NUM 12-bit measurement sources. Each source's latest sample is latched.
// Sources are picked round-robin, one per dwell period, and converted to BCD
// with a sequential shift/add-3 (double dabble), one bit per cycle.
// Optional feature: define SEG_FORCE_EN to add force_en/force_sel, which pin
// the pick to a single source.
//
// Handshake: src_val[i] is a one-cycle strobe with no back-pressure. The sample
// on src_data slice i is always accepted in the cycle src_val[i] is high.
// disp_val is a one-cycle strobe. It is high in the first cycle that the new
// digits and src_idx are visible.
module seg_disp_sched #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DWELL_MS = 1000,
    parameter int SRC_NUM  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SRC_NUM-1:0]    src_val,
    input  logic [12*SRC_NUM-1:0] src_data,
`ifdef SEG_FORCE_EN
    input  logic                  force_en,
    input  logic [1:0]            force_sel,
`endif
    output logic [3:0]            hun,
    output logic [3:0]            ten,
    output logic [3:0]            one,
    output logic [3:0]            dot,
    output logic [1:0]            src_idx,
    output logic                  disp_val,
    output logic                  busy
);

    localparam int DWELL_CYC = CLK_FREQ / 1000 * DWELL_MS;
    localparam int DW        = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
    localparam logic [3:0]    CONV_LAST  = 4'd11;
    localparam logic [2:0]    SRC_NUM3   = 3'(SRC_NUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        DONE  = 2'd2,
        DWELL = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    // Sample storage. The array always has four slots so that a 2-bit index
    // is always legal. Slots at or above SRC_NUM stay at zero.
    logic [11:0]   sreg [4];
    logic [3:0]    have;
    logic [3:0]    val_pad;

    // Conversion datapath
    logic [11:0]   bin_sr;
    logic [15:0]   acc;
    logic [15:0]   acc_adj;
    logic [3:0]    cnt;
    logic [1:0]    nxt_idx;
    logic [11:0]   fresh_data;

    // Dwell timing
    logic [DW-1:0] dwell_cnt;
    logic          refresh;

    // Pick result and FSM controls
    logic          pick_ok;
    logic [1:0]    pick_idx;
    logic [1:0]    cand;
    logic          snap_pick;
    logic          snap_refresh;
    logic          conv_step;
    logic          do_done;
    logic          dwell_clr;
    logic          dwell_inc;

    assign val_pad    = 4'(src_val);
    assign fresh_data = src_data[12*src_idx +: 12];
    assign busy       = (state == CONV);

    // Latch each source's newest sample and remember that it has ever reported
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) sreg[i] <= '0;
            have <= '0;
        end else begin
            for (int i = 0; i < SRC_NUM; i++) begin
                if (val_pad[i]) begin
                    sreg[i] <= src_data[12*i +: 12];
                    have[i] <= 1'b1;
                end
            end
        end
    end

    // Next-source pick: scan src_idx+1, src_idx+2, ... and check src_idx last.
    // The loop runs backwards so that the first hit in scan order is the one kept.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = 2'd0;
        cand     = 2'd0;
        for (int i = SRC_NUM; i >= 1; i--) begin
            cand = 2'((int'(src_idx) + i) % SRC_NUM);
            if (have[cand]) begin
                pick_ok  = 1'b1;
                pick_idx = cand;
            end
        end
`ifdef SEG_FORCE_EN
        // A forced selection that is out of range or has no data yields no pick
        if (force_en) begin
            pick_idx = force_sel;
            pick_ok  = ({1'b0, force_sel} < SRC_NUM3) && have[force_sel];
        end
`endif
    end

    // Add 3 to every BCD nibble that is 5 or more, before the next shift
    always_comb begin
        acc_adj = acc;
        for (int n = 0; n < 4; n++) begin
            if (acc[4*n +: 4] >= 4'd5) acc_adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and per-state controls. A refresh conversion keeps the
    // dwell counter running so that the period of the original pick is preserved.
    always_comb begin
        state_nxt    = state;
        snap_pick    = 1'b0;
        snap_refresh = 1'b0;
        conv_step    = 1'b0;
        do_done      = 1'b0;
        dwell_clr    = 1'b0;
        dwell_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    snap_pick = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                conv_step = 1'b1;
                dwell_inc = refresh;
                if (cnt == CONV_LAST) state_nxt = DONE;
            end
            DONE: begin
                do_done   = 1'b1;
                state_nxt = DWELL;
                if (refresh) dwell_inc = 1'b1;
                else         dwell_clr = 1'b1;
            end
            DWELL: begin
                // Expiry has priority over a refresh that arrives in the same cycle
                if (dwell_cnt == DWELL_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    dwell_inc = 1'b1;
                    if (val_pad[src_idx]) begin
                        snap_refresh = 1'b1;
                        state_nxt    = CONV;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot and double-dabble shift. A pick reads the stored sample (which is
    // the value before any same-cycle update). A refresh takes the new sample
    // directly from the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            acc     <= '0;
            cnt     <= '0;
            nxt_idx <= '0;
        end else if (snap_pick) begin
            bin_sr  <= sreg[pick_idx];
            acc     <= '0;
            cnt     <= '0;
            nxt_idx <= pick_idx;
        end else if (snap_refresh) begin
            bin_sr  <= fresh_data;
            acc     <= '0;
            cnt     <= '0;
            nxt_idx <= src_idx;
        end else if (conv_step) begin
            acc    <= {acc_adj[14:0], bin_sr[11]};
            bin_sr <= {bin_sr[10:0], 1'b0};
            cnt    <= cnt + 4'd1;
        end
    end

    // Publish the converted digits and source index with a one-cycle strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hun      <= '0;
            ten      <= '0;
            one      <= '0;
            dot      <= '0;
            src_idx  <= '0;
            disp_val <= 1'b0;
        end else begin
            disp_val <= do_done;
            if (do_done) begin
                hun     <= acc[15:12];
                ten     <= acc[11:8];
                one     <= acc[7:4];
                dot     <= acc[3:0];
                src_idx <= nxt_idx;
            end
        end
    end

    // Dwell counter (saturates at the last cycle) and refresh-in-progress flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            refresh   <= 1'b0;
        end else begin
            if (snap_pick)         refresh <= 1'b0;
            else if (snap_refresh) refresh <= 1'b1;

            if (dwell_clr) begin
                dwell_cnt <= '0;
            end else if (dwell_inc && (dwell_cnt != DWELL_LAST)) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: directed scenarios plus a randomized run for
// seg_disp_sched. A timestamp-based reference model predicts every output.
module tb_seg_disp_sched;

    localparam int CLK_FREQ  = 1000;
    localparam int DWELL_MS  = 10;
    localparam int SRC_NUM   = 4;
    localparam int DWELL_CYC = CLK_FREQ / 1000 * DWELL_MS;
    localparam int W         = 18;   // {src_idx, hun, ten, one, dot}
    localparam int BUDGET    = 80;

    logic        clk;
    logic        rst_n;
    logic [3:0]  src_val;
    logic [47:0] src_data;
    logic [3:0]  hun;
    logic [3:0]  ten;
    logic [3:0]  one;
    logic [3:0]  dot;
    logic [1:0]  src_idx;
    logic        disp_val;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    logic [W-1:0] exp_q[$];

    seg_disp_sched #(
        .CLK_FREQ(CLK_FREQ),
        .DWELL_MS(DWELL_MS),
        .SRC_NUM (SRC_NUM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_val  (src_val),
        .src_data (src_data),
`ifdef SEG_FORCE_EN
        .force_en (1'b0),
        .force_sel(2'd0),
`endif
        .hun      (hun),
        .ten      (ten),
        .one      (one),
        .dot      (dot),
        .src_idx  (src_idx),
        .disp_val (disp_val),
        .busy     (busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // The model works with cycle timestamps. A conversion that is snapshotted
    // at edge S is published at edge S+13. Busy is high after edges S..S+11.
    // The dwell of a display that was published at edge D ends at the first
    // DWELL edge k >= D+DWELL_CYC.
    localparam int M_IDLE  = 0;
    localparam int M_CONV  = 1;
    localparam int M_DWELL = 2;

    int          m_cyc, m_mode, m_snap_t, m_dwell_t, m_shown, m_conv_idx;
    bit          m_refresh, m_disp, m_busy;
    logic [11:0] m_reg [4];
    logic [3:0]  m_have;
    logic [11:0] m_conv_v;
    logic [15:0] m_digits;

    function automatic logic [15:0] to_bcd(input logic [11:0] v);
        int x;
        x = int'(v);
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic int model_pick();
        int c;
        for (int i = 1; i <= SRC_NUM; i++) begin
            c = (m_shown + i) % SRC_NUM;
            if (m_have[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_mode = M_IDLE; m_snap_t = 0; m_dwell_t = 0;
        m_shown = 0; m_conv_idx = 0; m_refresh = 0; m_disp = 0; m_busy = 0;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_have = '0; m_conv_v = '0; m_digits = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [3:0] sv, input logic [47:0] sd);
        int p;
        m_cyc++;
        m_disp = 0;
        if (m_mode == M_IDLE) begin
            p = model_pick();
            if (p >= 0) begin
                m_conv_v = m_reg[p]; m_conv_idx = p; m_snap_t = m_cyc;
                m_refresh = 0; m_mode = M_CONV;
            end
        end else if (m_mode == M_CONV) begin
            if (m_cyc == m_snap_t + 13) begin
                m_digits = to_bcd(m_conv_v);
                m_shown  = m_conv_idx;
                m_disp   = 1;
                exp_q.push_back({2'(m_shown), m_digits});
                if (!m_refresh) m_dwell_t = m_cyc;
                m_mode = M_DWELL;
            end
        end else begin
            if (m_cyc >= m_dwell_t + DWELL_CYC) begin
                m_mode = M_IDLE;
            end else if (sv[m_shown[1:0]]) begin
                m_conv_v = sd[12*m_shown +: 12]; m_conv_idx = m_shown;
                m_snap_t = m_cyc; m_refresh = 1; m_mode = M_CONV;
            end
        end
        m_busy = (m_mode == M_CONV) && (m_cyc <= m_snap_t + 11);
        for (int s = 0; s < SRC_NUM; s++) begin
            if (sv[s]) begin
                m_reg[s]  = sd[12*s +: 12];
                m_have[s] = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step(src_val, src_data);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                check("disp_val", 32'(disp_val), 32'(m_disp));
                check("busy", 32'(busy), 32'(m_busy));
                check("digits", {16'd0, hun, ten, one, dot}, {16'd0, m_digits});
                check("src_idx", 32'(src_idx), 32'(m_shown));
                if (disp_val) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL disp_word actual=%0h expected=none", {src_idx, hun, ten, one, dot});
                    end else begin
                        check("disp_word", 32'({src_idx, hun, ten, one, dot}), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        chk_en  = 0;
        src_val = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1;
    endtask

    task automatic pulse(input int s, input logic [11:0] d);
        src_val = 4'(1 << s);
        src_data[12*s +: 12] = d;
        @(negedge clk);
        src_val = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_disp(output logic [W-1:0] got, output int waited,
                             output int nbusy, output int at);
        got = '0; waited = 0; nbusy = 0; at = -1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            waited++;
            if (busy) nbusy++;
            if (disp_val) begin
                got = {src_idx, hun, ten, one, dot};
                at  = int'($time / 10);
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_disp actual=no_pulse required=pulse_within_%0d", BUDGET);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] got;
        int waited, nbusy, at0, at1, at2, n_disp;
        bit seen;

        rst_n = 1'b0; src_val = '0; src_data = '0;

        // 1: idle after reset
        do_reset();
        n_disp = 0;
        repeat (100) begin
            @(negedge clk);
            if (disp_val) n_disp++;
        end
        check("t1_no_disp", 32'(n_disp), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_digits", {16'd0, hun, ten, one, dot}, 32'h0);

        // 2: max value, latency and busy length, then async reset mid-conversion
        do_reset();
        pulse(0, 12'd4095);
        wait_disp(got, waited, nbusy, at0);
        check("t2_word", 32'(got), 32'({2'd0, 16'h4095}));
        check("t2_latency", 32'(waited), 32'd14);
        check("t2_busy_len", 32'(nbusy), 32'd12);
        seen = 0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        check("t2_repick_busy", 32'(seen), 32'd1);
        idle(3);
        #1;
        chk_en = 0;
        rst_n  = 1'b0;
        #1;
        check("t2_async_busy", 32'(busy), 32'd0);
        check("t2_async_digits", {16'd0, hun, ten, one, dot}, 32'h0);
        check("t2_async_disp", 32'(disp_val), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1;

        // 3: two sources alternate, empty slots skipped
        do_reset();
        pulse(0, 12'd123);
        pulse(2, 12'd7);
        wait_disp(got, waited, nbusy, at0);
        check("t3_first", 32'(got), 32'({2'd0, 16'h0123}));
        wait_disp(got, waited, nbusy, at1);
        check("t3_second", 32'(got), 32'({2'd2, 16'h0007}));
        check("t3_spacing_a", 32'(at1 - at0), 32'd24);
        wait_disp(got, waited, nbusy, at2);
        check("t3_third", 32'(got), 32'({2'd0, 16'h0123}));
        check("t3_spacing_b", 32'(at2 - at1), 32'd24);

        // 4: refresh of the shown source at dwell cycle 4
        do_reset();
        pulse(0, 12'd500);
        wait_disp(got, waited, nbusy, at0);
        check("t4_first", 32'(got), 32'({2'd0, 16'h0500}));
        idle(4);
        pulse(0, 12'd999);
        wait_disp(got, waited, nbusy, at1);
        check("t4_refresh", 32'(got), 32'({2'd0, 16'h0999}));
        check("t4_refresh_time", 32'(at1 - at0), 32'd18);
        wait_disp(got, waited, nbusy, at2);
        check("t4_repick", 32'(got), 32'({2'd0, 16'h0999}));

        // 5: new sample during conversion does not disturb it
        do_reset();
        pulse(1, 12'd60);
        idle(1);
        pulse(1, 12'd50);
        wait_disp(got, waited, nbusy, at0);
        check("t5_old", 32'(got), 32'({2'd1, 16'h0060}));
        wait_disp(got, waited, nbusy, at1);
        check("t5_new", 32'(got), 32'({2'd1, 16'h0050}));

        // 6: randomized strobes and data, checked cycle by cycle against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] v;
            v = '0;
            for (int s = 0; s < SRC_NUM; s++) begin
                case ($urandom_range(0, 3))
                    0:       src_data[12*s +: 12] = 12'd0;
                    1:       src_data[12*s +: 12] = 12'd4095;
                    default: src_data[12*s +: 12] = 12'($urandom);
                endcase
                if ($urandom_range(0, 24) == 0) v = v | 4'(1 << s);
            end
            src_val = v;
            @(negedge clk);
        end
        src_val = '0;
        idle(60);
        #1;
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
